// File: rtl/sram_port_arbiter.sv
// Shares one 16-bit asynchronous SRAM between the instruction-fetch and data ports,
// splitting 32-bit accesses into two halfword cycles and extending loads per RV32I funct3.
module sram_port_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int ACCESS_CYC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_i_req,
    input  logic [ADDR_W-1:0] i_i_addr,
    output logic              o_i_done,
    output logic [31:0]       o_i_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [2:0]        i_d_funct3,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_done,
    output logic              o_d_err,
    output logic [31:0]       o_d_rdata,
    output logic              o_busy,
    output logic [19:0]       o_SRAM_ADDR,
    inout  wire  [15:0]       io_SRAM_DQ,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC_HI = 2'd1,
        S_ACC_LO = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int              CNT_W    = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);

    // Illegal funct3 for the direction, or address not aligned to the access size.
    function automatic logic f_req_err(input logic i_we, input logic [2:0] i_f3,
                                       input logic [1:0] i_a);
        logic bad_f3;
        logic misal;
        bad_f3 = i_we ? (i_f3 >= 3'b011) : ((i_f3 == 3'b011) || (i_f3[2:1] == 2'b11));
        misal  = ((i_f3[1:0] == 2'b10) && (i_a != 2'b00)) ||
                 ((i_f3[1:0] == 2'b01) && i_a[0]);
        return bad_f3 || misal;
    endfunction

    // Even byte address lives in the upper lane of the halfword.
    function automatic logic [31:0] f_load_ext(input logic [2:0] i_f3, input logic i_a0,
                                               input logic [15:0] i_hw);
        logic [7:0] b;
        b = i_a0 ? i_hw[7:0] : i_hw[15:8];
        case (i_f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{i_hw[15]}}, i_hw};
            default: return {16'd0, i_hw};
        endcase
    endfunction

    state_t             r_state;
    state_t             w_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_data;

    logic               r_is_data;
    logic               r_we;
    logic [2:0]         r_f3;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_err;
    logic [15:0]        r_hi;

    logic               r_i_done;
    logic               r_d_done;
    logic               r_d_err;
    logic [31:0]        r_i_rdata;
    logic [31:0]        r_d_rdata;

    logic [19:0]        r_sram_addr;
    logic               r_oe_n;
    logic               r_we_n;
    logic               r_lb_n;
    logic               r_ub_n;
    logic               r_dq_oe;
    logic [15:0]        r_dq_out;

    logic               w_grant_d;
    logic               w_grant_i;
    logic               w_grant;
    logic               w_sel_is_data;
    logic               w_sel_we;
    logic [2:0]         w_sel_f3;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic               w_sel_err;
    logic               w_word;
    logic               w_last;
    logic               w_acc_nxt;
    logic [ADDR_W-2:0]  w_hw_addr;
    logic [19:0]        w_sram_addr;
    logic               w_oe_n;
    logic               w_we_n;
    logic               w_lb_n;
    logic               w_ub_n;
    logic               w_dq_oe;
    logic [15:0]        w_dq_out;

    // Data wins a tie unless it was the last one granted.
    assign w_grant_d = (r_state == S_IDLE) && i_d_req && (!i_i_req || !r_last_data);
    assign w_grant_i = (r_state == S_IDLE) && i_i_req && !w_grant_d;
    assign w_grant   = w_grant_d || w_grant_i;

    // In IDLE the winner's live inputs are used; afterwards the latched copy.
    always_comb begin
        w_sel_is_data = r_is_data;
        w_sel_we      = r_we;
        w_sel_f3      = r_f3;
        w_sel_addr    = r_addr;
        w_sel_wdata   = r_wdata;
        w_sel_err     = r_err;
        if (r_state == S_IDLE) begin
            w_sel_is_data = w_grant_d;
            if (w_grant_d) begin
                w_sel_we    = i_d_we;
                w_sel_f3    = i_d_funct3;
                w_sel_addr  = i_d_addr;
                w_sel_wdata = i_d_wdata;
                w_sel_err   = f_req_err(i_d_we, i_d_funct3, i_d_addr[1:0]);
            end else begin
                w_sel_we    = 1'b0;
                w_sel_f3    = 3'b010;
                w_sel_addr  = i_i_addr;
                w_sel_wdata = 32'd0;
                w_sel_err   = 1'b0;
            end
        end
    end

    assign w_word = (w_sel_f3[1:0] == 2'b10);
    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_nxt = w_sel_err ? S_DONE : S_ACC_HI;
                end
            end
            S_ACC_HI: begin
                if (w_last) begin
                    w_nxt = w_word ? S_ACC_LO : S_DONE;
                end
            end
            S_ACC_LO: begin
                if (w_last) begin
                    w_nxt = S_DONE;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // SRAM pin values for the coming cycle, registered so the pins never glitch.
    always_comb begin
        w_acc_nxt   = (w_nxt == S_ACC_HI) || (w_nxt == S_ACC_LO);
        w_hw_addr   = w_sel_addr[ADDR_W-1:1];
        w_sram_addr = r_sram_addr;
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_lb_n      = 1'b1;
        w_ub_n      = 1'b1;
        w_dq_oe     = 1'b0;
        w_dq_out    = r_dq_out;
        if (w_word) begin
            w_hw_addr = {w_sel_addr[ADDR_W-1:2], (w_nxt == S_ACC_LO)};
        end
        if (w_acc_nxt) begin
            w_sram_addr = 20'(w_hw_addr);
            w_oe_n      = w_sel_we;
            w_we_n      = !w_sel_we;
            w_dq_oe     = w_sel_we;
            if (w_sel_f3[1:0] == 2'b00) begin
                w_lb_n   = !w_sel_addr[0];
                w_ub_n   = w_sel_addr[0];
                w_dq_out = {w_sel_wdata[7:0], w_sel_wdata[7:0]};
            end else begin
                w_lb_n   = 1'b0;
                w_ub_n   = 1'b0;
                w_dq_out = (w_word && (w_nxt == S_ACC_HI)) ? w_sel_wdata[31:16]
                                                           : w_sel_wdata[15:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_last_data <= 1'b0;
            r_sram_addr <= 20'd0;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_lb_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_i_rdata   <= 32'd0;
            r_d_rdata   <= 32'd0;
        end else begin
            if (((r_state == S_ACC_HI) || (r_state == S_ACC_LO)) && !w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_grant) begin
                r_last_data <= w_grant_d;
            end
            r_sram_addr <= w_sram_addr;
            r_oe_n      <= w_oe_n;
            r_we_n      <= w_we_n;
            r_lb_n      <= w_lb_n;
            r_ub_n      <= w_ub_n;
            r_dq_oe     <= w_dq_oe;
            r_i_done    <= (w_nxt == S_DONE) && !w_sel_is_data;
            r_d_done    <= (w_nxt == S_DONE) && w_sel_is_data;
            r_d_err     <= (w_nxt == S_DONE) && w_sel_is_data && w_sel_err;
            if (w_grant_d && w_sel_err) begin
                r_d_rdata <= 32'd0;
            end
            if ((r_state == S_ACC_HI) && w_last && !w_word && r_is_data) begin
                r_d_rdata <= r_we ? 32'd0 : f_load_ext(r_f3, r_addr[0], io_SRAM_DQ);
            end
            if ((r_state == S_ACC_LO) && w_last) begin
                if (r_is_data) begin
                    r_d_rdata <= r_we ? 32'd0 : {r_hi, io_SRAM_DQ};
                end else begin
                    r_i_rdata <= {r_hi, io_SRAM_DQ};
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_grant) begin
            r_is_data <= w_sel_is_data;
            r_we      <= w_sel_we;
            r_f3      <= w_sel_f3;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_err     <= w_sel_err;
        end
        if ((r_state == S_ACC_HI) && w_last) begin
            r_hi <= io_SRAM_DQ;
        end
        r_dq_out <= w_dq_out;
    end

    assign io_SRAM_DQ  = r_dq_oe ? r_dq_out : 16'bz;
    assign o_SRAM_ADDR = r_sram_addr;
    assign o_SRAM_CE_N = 1'b0;
    assign o_SRAM_OE_N = r_oe_n;
    assign o_SRAM_WE_N = r_we_n;
    assign o_SRAM_LB_N = r_lb_n;
    assign o_SRAM_UB_N = r_ub_n;
    assign o_i_done    = r_i_done;
    assign o_i_rdata   = r_i_rdata;
    assign o_d_done    = r_d_done;
    assign o_d_err     = r_d_err;
    assign o_d_rdata   = r_d_rdata;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM on the pins and a byte-array
// reference of memory contents and port semantics.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [20:0] i_addr = 21'd0;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_f3 = 3'd0;
    logic [20:0] d_addr = 21'd0;
    logic [31:0] d_wdata = 32'd0;
    logic        d_done;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        busy;
    logic [19:0] s_addr;
    wire  [15:0] dq;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_i_req(i_req), .i_i_addr(i_addr), .o_i_done(i_done), .o_i_rdata(i_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_funct3(d_f3), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_done(d_done), .o_d_err(d_err), .o_d_rdata(d_rdata),
        .o_busy(busy), .o_SRAM_ADDR(s_addr), .io_SRAM_DQ(dq),
        .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
        .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );

    // SRAM model: halfword array on the pins, byte array as the reference view.
    logic [15:0] sram [0:1023];
    logic [7:0]  ref_mem [0:2047];
    logic        load_mem = 1'b0;

    assign dq = (!ce_n && !oe_n && we_n) ? sram[s_addr[9:0]] : 16'bz;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 1024; i++) sram[i] <= {ref_mem[2*i], ref_mem[2*i+1]};
        end else if (!ce_n && !we_n) begin
            if (!ub_n) sram[s_addr[9:0]][15:8] <= dq[15:8];
            if (!lb_n) sram[s_addr[9:0]][7:0]  <= dq[7:0];
        end
    end

    int          we_lo_cnt = 0;
    int          act_cnt = 0;
    logic [19:0] mon_addr = 20'd0;
    logic [15:0] mon_dq = 16'd0;
    logic        mon_lb = 1'b1;
    logic        mon_ub = 1'b1;

    always @(negedge clk) begin
        if (!we_n) begin
            we_lo_cnt <= we_lo_cnt + 1;
            mon_addr  <= s_addr;
            mon_dq    <= dq;
            mon_lb    <= lb_n;
            mon_ub    <= ub_n;
        end
        if (!we_n || !oe_n) act_cnt <= act_cnt + 1;
    end

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input int a);
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        return (a % size_of(f3)) != 0;
    endfunction

    // Memory is big-endian in byte order: lower byte address is more significant.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
        int v;
        case (f3)
            3'b000: begin v = ref_mem[a]; if (v > 127) v -= 256; end
            3'b100: v = ref_mem[a];
            3'b001: begin v = ref_mem[a] * 256 + ref_mem[a+1]; if (v > 32767) v -= 65536; end
            3'b101: v = ref_mem[a] * 256 + ref_mem[a+1];
            default: return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
        endcase
        return 32'(v);
    endfunction

    task automatic model_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
        int n;
        n = size_of(f3);
        for (int i = 0; i < n; i++) ref_mem[a+i] = 8'(wd >> (8 * (n - 1 - i)));
    endtask

    task automatic run_data(input logic we, input logic [2:0] f3, input int a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic er, output int lat);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_f3 = f3; d_addr = 21'(a); d_wdata = wd;
        lat = -1; rd = 32'd0; er = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d_done) begin lat = k; rd = d_rdata; er = d_err; break; end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic run_fetch(input int a, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 21'(a);
        lat = -1; rd = 32'd0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_done) begin lat = k; rd = i_rdata; break; end
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'($urandom);
        ref_mem[16] = 8'h12; ref_mem[17] = 8'h34; ref_mem[18] = 8'hAB; ref_mem[19] = 8'hCD;
        ref_mem[2]  = 8'h80; ref_mem[3]  = 8'hFF;
        @(posedge clk); #1 load_mem = 1'b1;
        @(posedge clk); #1 load_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_mem();
        @(negedge clk);
        checks += 12;
        if (we_n !== 1'b1)     begin errors++; $display("FAIL rst_we_n: got %b want 1", we_n); end
        if (oe_n !== 1'b1)     begin errors++; $display("FAIL rst_oe_n: got %b want 1", oe_n); end
        if (lb_n !== 1'b1)     begin errors++; $display("FAIL rst_lb_n: got %b want 1", lb_n); end
        if (ub_n !== 1'b1)     begin errors++; $display("FAIL rst_ub_n: got %b want 1", ub_n); end
        if (ce_n !== 1'b0)     begin errors++; $display("FAIL rst_ce_n: got %b want 0", ce_n); end
        if (s_addr !== 20'd0)  begin errors++; $display("FAIL rst_addr: got %h want 0", s_addr); end
        if (i_done !== 1'b0)   begin errors++; $display("FAIL rst_i_done: got %b want 0", i_done); end
        if (d_done !== 1'b0)   begin errors++; $display("FAIL rst_d_done: got %b want 0", d_done); end
        if (d_err !== 1'b0)    begin errors++; $display("FAIL rst_d_err: got %b want 0", d_err); end
        if (i_rdata !== 32'd0) begin errors++; $display("FAIL rst_i_rdata: got %h want 0", i_rdata); end
        if (d_rdata !== 32'd0) begin errors++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
    endtask

    // Both ports held requesting: grants must alternate, data first after reset.
    task automatic test_arbitration();
        logic exp_data;
        int   n;
        exp_data = 1'b1;
        n = 0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 21'h10;
        d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 21'h20; d_wdata = 32'd0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (i_done || d_done) begin
                checks += 2;
                if (d_done !== exp_data || i_done !== !exp_data) begin
                    errors++;
                    $display("FAIL arb_order[%0d]: got d_done=%b i_done=%b want d_done=%b",
                             n, d_done, i_done, exp_data);
                end
                if (exp_data && d_rdata !== model_load(3'b010, 32)) begin
                    errors++;
                    $display("FAIL arb_d_rdata[%0d]: got %h want %h", n, d_rdata, model_load(3'b010, 32));
                end else if (!exp_data && i_rdata !== model_load(3'b010, 16)) begin
                    errors++;
                    $display("FAIL arb_i_rdata[%0d]: got %h want %h", n, i_rdata, model_load(3'b010, 16));
                end
                exp_data = !exp_data;
                n++;
            end
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL arb_timeout: got %0d dones want 4", n); end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] rd;
        int          lat;
        run_fetch(32'h10, rd, lat);
        checks += 3;
        if (lat != 3)          begin errors++; $display("FAIL fetch_lat: got %0d want 3", lat); end
        if (rd !== 32'h1234ABCD) begin errors++; $display("FAIL fetch_rdata: got %h want 1234abcd", rd); end
        @(negedge clk);
        if (i_done !== 1'b0)   begin errors++; $display("FAIL fetch_pulse: got %b want 0", i_done); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] rd;
        logic        er;
        int          lat;
        run_data(1'b0, 3'b000, 2, 32'd0, rd, er, lat);
        checks += 3;
        if (lat != 2)            begin errors++; $display("FAIL lb_lat: got %0d want 2", lat); end
        if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", rd); end
        if (er !== 1'b0)         begin errors++; $display("FAIL lb_err: got %b want 0", er); end
        run_data(1'b0, 3'b100, 2, 32'd0, rd, er, lat);
        checks += 2;
        if (lat != 2)            begin errors++; $display("FAIL lbu_lat: got %0d want 2", lat); end
        if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata: got %h want 00000080", rd); end
    endtask

    task automatic test_store_byte();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w0;
        w0 = we_lo_cnt;
        run_data(1'b1, 3'b000, 3, 32'hA5A5A55A, rd, er, lat);
        model_store(3'b000, 3, 32'hA5A5A55A);
        checks += 7;
        if (lat != 2)               begin errors++; $display("FAIL sb_lat: got %0d want 2", lat); end
        if (er !== 1'b0)            begin errors++; $display("FAIL sb_err: got %b want 0", er); end
        if (we_lo_cnt - w0 != 1)    begin errors++; $display("FAIL sb_we_cycles: got %0d want 1", we_lo_cnt - w0); end
        if (mon_addr !== 20'd1)     begin errors++; $display("FAIL sb_addr: got %h want 1", mon_addr); end
        if (mon_lb !== 1'b0)        begin errors++; $display("FAIL sb_lb_n: got %b want 0", mon_lb); end
        if (mon_ub !== 1'b1)        begin errors++; $display("FAIL sb_ub_n: got %b want 1", mon_ub); end
        if (mon_dq[7:0] !== 8'h5A)  begin errors++; $display("FAIL sb_dq: got %h want 5a", mon_dq[7:0]); end
        run_data(1'b0, 3'b101, 2, 32'd0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000805A)    begin errors++; $display("FAIL sb_readback: got %h want 0000805a", rd); end
    endtask

    task automatic test_errors();
        logic        we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3_t [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        int          a_t  [4] = '{6, 1, 0, 0};
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          a0;
        for (int i = 0; i < 4; i++) begin
            a0 = act_cnt;
            run_data(we_t[i], f3_t[i], a_t[i], 32'hDEADBEEF, rd, er, lat);
            checks += 4;
            if (lat != 1)       begin errors++; $display("FAIL err_lat[%0d]: got %0d want 1", i, lat); end
            if (er !== 1'b1)    begin errors++; $display("FAIL err_flag[%0d]: got %b want 1", i, er); end
            if (rd !== 32'd0)   begin errors++; $display("FAIL err_rdata[%0d]: got %h want 0", i, rd); end
            if (act_cnt != a0)  begin errors++; $display("FAIL err_sram_cycles[%0d]: got %0d want 0", i, act_cnt - a0); end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] wd, rd, e_rd;
        logic        er, e_err;
        int          a, sz, lat, e_lat, e_we, w0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 255) * 4;
                run_fetch(a, rd, lat);
                checks += 2;
                if (lat != 3) begin errors++; $display("FAIL rnd_fetch_lat[%0d]: got %0d want 3", n, lat); end
                if (rd !== model_load(3'b010, a)) begin
                    errors++; $display("FAIL rnd_fetch_rdata[%0d]: got %h want %h", n, rd, model_load(3'b010, a));
                end
            end else begin
                we = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                sz = size_of(f3);
                a  = $urandom_range(0, 1019);
                if ($urandom_range(0, 1) == 1) a = a - (a % sz);
                wd = $urandom;
                e_err = model_err(we, f3, a);
                e_lat = e_err ? 1 : ((sz == 4) ? 3 : 2);
                e_we  = (we && !e_err) ? ((sz == 4) ? 2 : 1) : 0;
                e_rd  = (!we && !e_err) ? model_load(f3, a) : 32'd0;
                w0 = we_lo_cnt;
                run_data(we, f3, a, wd, rd, er, lat);
                checks += 3;
                if (lat != e_lat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", n, lat, e_lat); end
                if (er !== e_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b want %b", n, er, e_err); end
                if (we_lo_cnt - w0 != e_we) begin
                    errors++; $display("FAIL rnd_we_cycles[%0d]: got %0d want %0d", n, we_lo_cnt - w0, e_we);
                end
                if (!we || e_err) begin
                    checks++;
                    if (rd !== e_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rd, e_rd); end
                end
                if (we && !e_err) model_store(f3, a, wd);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        int          lat;
        logic        seen;
        logic        got_done;
        seen = 1'b0;
        got_done = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_f3 = 3'b010; d_addr = 21'h500; d_wdata = 32'h01234567;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!we_n && s_addr[0]) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_reach_lo: got 0 want 1"); end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (we_n !== 1'b1) begin errors++; $display("FAIL rstmid_we_n: got %b want 1", we_n); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (d_done) got_done = 1'b1;
            if (k == 1) rst_n = 1'b1;
        end
        checks++;
        if (got_done) begin errors++; $display("FAIL rstmid_no_done: got 1 want 0"); end
        run_fetch(16, rd, lat);
        checks += 2;
        if (lat != 3) begin errors++; $display("FAIL rstmid_fetch_lat: got %0d want 3", lat); end
        if (rd !== model_load(3'b010, 16)) begin
            errors++; $display("FAIL rstmid_fetch_rdata: got %h want %h", rd, model_load(3'b010, 16));
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_fetch();
        test_byte_loads();
        test_store_byte();
        test_errors();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
